// File: rtl/nested_entry_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nested_entry_queue_pkg
// Description : Shared types and default constants for the nested entry
//               queue: the TABLE_ENTRY row layout and parameter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package nested_entry_queue_pkg;

  localparam int FID_W  = 16;   // field identifier width
  localparam int OFF_W  = 16;   // nested-object offset width
  localparam int TYPE_W = 4;    // wire-type code width

  localparam int DEF_DEPTH       = 64;
  localparam int DEF_STACK_DEPTH = 16;
  localparam int DEF_ADDR_W      = 64;

  // One decoded descriptor-table row. field_id == 0 marks end-of-object.
  typedef struct packed {
    logic [FID_W-1:0]  field_id;
    logic              nested;
    logic [OFF_W-1:0]  offset;
    logic [TYPE_W-1:0] wire_type;
  } table_entry_t;

  function automatic logic is_marker(input table_entry_t e);
    return (e.field_id == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nested_entry_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : nested_entry_queue_if
// Description : Entry stream bundle: upstream entry handshake from the fetch
//               unit and downstream entry/address handshake to serializers.
//               slave = the queue, master = its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface nested_entry_queue_if
  import nested_entry_queue_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  table_entry_t      in_entry;
  logic              in_valid;
  logic              in_ready;
  table_entry_t      out_entry;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_base_addr;

  modport master (
    output in_entry, in_valid, out_ready,
    input  in_ready, out_entry, out_valid, out_base_addr
  );

  modport slave (
    input  in_entry, in_valid, out_ready,
    output in_ready, out_entry, out_valid, out_base_addr
  );

endinterface
`default_nettype wire

// File: rtl/nested_entry_queue_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : nested_entry_queue_addr_stack
// Description : Register stack of object base addresses. Row 0 is the root
//               and is loadable; push/pop move the level. A push at the top
//               row or a pop at the root is dropped and flagged for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module nested_entry_queue_addr_stack
  import nested_entry_queue_pkg::*;
#(
  parameter int DEPTH = DEF_STACK_DEPTH,
  parameter int WIDTH = DEF_ADDR_W
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  input  wire logic                     load,
  input  wire logic [WIDTH-1:0]         load_data,
  output logic      [WIDTH-1:0]         top,
  output logic      [$clog2(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int               LVL_W   = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH - 1);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;

  // Next stack contents and level from load/push/pop requests.
  always_comb begin
    stack_d   = stack_q;
    level_d   = level_q;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (load) begin
      stack_d[0] = load_data;
    end
    if (push) begin
      if (level_q == LVL_MAX) begin
        overflow = 1'b1;
      end else begin
        level_d          = level_q + LVL_W'(1);
        stack_d[level_d] = push_data;
      end
    end else if (pop) begin
      if (level_q == '0) begin
        underflow = 1'b1;
      end else begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  // Stack register; only the root row and level are reset, deeper rows are
  // unreachable until pushed again.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q    <= '0;
      stack_q[0] <= '0;
    end else begin
      level_q <= level_d;
      stack_q <= stack_d;
    end
  end

  assign top   = stack_q[level_q];
  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/nested_entry_queue.sv
`default_nettype none
// ============================================================================
// Module      : nested_entry_queue
// Description : In-order circular queue of decoded table entries presented
//               to the serializers, with a nesting stack so each presented
//               entry carries the base address of its enclosing object.
//               End-of-object markers are consumed internally and pop the
//               stack; accepted nested entries push parent + offset.
// Revision    : 1.0 - initial release
// ============================================================================
module nested_entry_queue
  import nested_entry_queue_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  wire logic                           clk,
  input  wire logic                           reset,
  nested_entry_queue_if.slave                 bus,
  input  wire logic [ADDR_W-1:0]              base_addr,
  input  wire logic                           base_addr_valid,
  output logic      [$clog2(DEPTH+1)-1:0]     count,
  output logic      [$clog2(STACK_DEPTH)-1:0] level,
  output logic                                idle,
  output logic                                err_overflow,
  output logic                                err_underflow,
  output logic                                err_load,
  input  wire logic                           err_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LVL_W = $clog2(STACK_DEPTH);

  table_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_underflow_q, err_underflow_d;
  logic              err_load_q, err_load_d;

  table_entry_t      head;
  logic              empty, full, head_marker;
  logic              in_ready_w, out_valid_w;
  logic              enq, data_fire, marker_drop, deq;
  logic              push, pop, load_ok, idle_w;
  logic [ADDR_W-1:0] stack_top;
  logic [LVL_W-1:0]  stack_level;
  logic              stk_overflow, stk_underflow;

  // Handshake decode: classify the head row and derive enqueue/dequeue.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    empty       = (count_q == '0);
    full        = (count_q == CNT_W'(DEPTH));
    head_marker = is_marker(head);
    in_ready_w  = !full && !reset;
    out_valid_w = !empty && !head_marker && !reset;
    enq         = bus.in_valid && in_ready_w;
    data_fire   = out_valid_w && bus.out_ready;
    // A marker never reaches the serializers; it leaves the head on its own.
    marker_drop = !empty && head_marker && !reset;
    deq         = data_fire || marker_drop;
    push        = data_fire && head.nested;
    pop         = marker_drop;
    idle_w      = empty && (stack_level == '0);
    load_ok     = base_addr_valid && idle_w && !reset;
  end

  // Pointer, occupancy and sticky error next-state.
  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Clearing wins over a flag raised in the same cycle.
    err_overflow_d  = err_clear ? 1'b0 : (err_overflow_q  || stk_overflow);
    err_underflow_d = err_clear ? 1'b0 : (err_underflow_q || stk_underflow);
    err_load_d      = err_clear ? 1'b0 : (err_load_q || (base_addr_valid && !idle_w));
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_load_q      <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
      err_load_q      <= err_load_d;
    end
  end

  // Queue storage; contents survive reset and are hidden by the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= bus.in_entry;
    end
  end

  nested_entry_queue_addr_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_addr_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (stack_top + ADDR_W'(head.offset)),
    .pop       (pop),
    .load      (load_ok),
    .load_data (base_addr),
    .top       (stack_top),
    .level     (stack_level),
    .overflow  (stk_overflow),
    .underflow (stk_underflow)
  );

  assign bus.in_ready      = in_ready_w;
  assign bus.out_valid     = out_valid_w;
  assign bus.out_entry     = out_valid_w ? head : '0;
  assign bus.out_base_addr = stack_top;
  assign count             = count_q;
  assign level             = stack_level;
  assign idle              = idle_w;
  assign err_overflow      = err_overflow_q;
  assign err_underflow     = err_underflow_q;
  assign err_load          = err_load_q;

endmodule
`default_nettype wire

// File: tb/tb_nested_entry_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_nested_entry_queue
// Description : Directed self-checking bench for nested_entry_queue with
//               hand-computed expected values and a small in-order model
//               for the full/streaming phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nested_entry_queue;
  import nested_entry_queue_pkg::*;

  localparam int DEPTH       = 64;
  localparam int STACK_DEPTH = 4;
  localparam int ADDR_W      = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              base_addr_valid = 1'b0;
  logic              err_clear = 1'b0;
  logic [6:0]        count;
  logic [1:0]        level;
  logic              idle, err_overflow, err_underflow, err_load;

  int n_checks = 0;
  int n_fail   = 0;

  nested_entry_queue_if #(.ADDR_W(ADDR_W)) bus ();

  nested_entry_queue #(
    .DEPTH       (DEPTH),
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .base_addr       (base_addr),
    .base_addr_valid (base_addr_valid),
    .count           (count),
    .level           (level),
    .idle            (idle),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow),
    .err_load        (err_load),
    .err_clear       (err_clear)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic table_entry_t mk(input logic [15:0] fid, input logic nst,
                                      input logic [15:0] off, input logic [3:0] typ);
    table_entry_t e;
    e.field_id  = fid;
    e.nested    = nst;
    e.offset    = off;
    e.wire_type = typ;
    return e;
  endfunction

  function automatic table_entry_t data_ent(input int id);
    return mk(16'(id), 1'b0, 16'(id * 3), 4'(id));
  endfunction

  table_entry_t mq[$];
  table_entry_t marker;
  table_entry_t n1, n2, n3, n4, d7, d8;
  int           next_id;
  logic         exp_rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    marker = mk(16'd0, 1'b0, 16'd0, 4'd0);
    bus.in_valid  = 1'b0;
    bus.in_entry  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick(); tick(); settle();
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_idle", 64'(idle), 64'd1);
    tick(); reset = 1'b0; settle();
    check_eq("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("post_rst_out_entry", 64'(bus.out_entry), 64'd0);
    check_eq("post_rst_base", bus.out_base_addr, 64'd0);
    check_eq("post_rst_errs", 64'({err_overflow, err_underflow, err_load}), 64'd0);

    // Root load and three flat data entries
    base_addr = 64'h1000; base_addr_valid = 1'b1;
    tick(); base_addr_valid = 1'b0; settle();
    check_eq("root_load", bus.out_base_addr, 64'h1000);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_entry = data_ent(1);
    tick(); bus.in_entry = data_ent(2); settle();
    check_eq("flat_v1", 64'(bus.out_valid), 64'd1);
    check_eq("flat_e1", 64'(bus.out_entry), 64'(data_ent(1)));
    check_eq("flat_a1", bus.out_base_addr, 64'h1000);
    tick(); bus.in_entry = data_ent(3); settle();
    check_eq("flat_e2", 64'(bus.out_entry), 64'(data_ent(2)));
    check_eq("flat_cnt", 64'(count), 64'd1);
    tick(); bus.in_valid = 1'b0; settle();
    check_eq("flat_e3", 64'(bus.out_entry), 64'(data_ent(3)));
    check_eq("flat_a3", bus.out_base_addr, 64'h1000);
    tick(); settle();
    check_eq("flat_drained_v", 64'(bus.out_valid), 64'd0);
    check_eq("flat_idle", 64'(idle), 64'd1);

    // One nesting level: nested, data, marker, data
    n1 = mk(16'd5, 1'b1, 16'h40, 4'd2);
    d7 = data_ent(7);
    d8 = data_ent(8);
    bus.in_valid = 1'b1; bus.in_entry = n1;
    tick(); bus.in_entry = d7; settle();
    check_eq("nest_self_entry", 64'(bus.out_entry), 64'(n1));
    check_eq("nest_parent_addr", bus.out_base_addr, 64'h1000);
    tick(); bus.in_entry = marker; settle();
    check_eq("nest_child_entry", 64'(bus.out_entry), 64'(d7));
    check_eq("nest_child_addr", bus.out_base_addr, 64'h1040);
    check_eq("nest_child_level", 64'(level), 64'd1);
    tick(); bus.in_entry = d8; settle();
    check_eq("nest_bubble", 64'(bus.out_valid), 64'd0);
    check_eq("nest_bubble_level", 64'(level), 64'd1);
    tick(); bus.in_valid = 1'b0; settle();
    check_eq("nest_after_entry", 64'(bus.out_entry), 64'(d8));
    check_eq("nest_after_addr", bus.out_base_addr, 64'h1000);
    check_eq("nest_after_level", 64'(level), 64'd0);
    tick(); settle();
    check_eq("nest_idle", 64'(idle), 64'd1);

    // Three levels, then an overflowing fourth nest, then unwind
    n1 = mk(16'd10, 1'b1, 16'h10, 4'd1);
    n2 = mk(16'd11, 1'b1, 16'h20, 4'd1);
    n3 = mk(16'd12, 1'b1, 16'h30, 4'd1);
    n4 = mk(16'd13, 1'b1, 16'h50, 4'd1);
    bus.in_valid = 1'b1; bus.in_entry = n1;
    tick(); bus.in_entry = n2; settle();
    check_eq("deep_a0", bus.out_base_addr, 64'h1000);
    tick(); bus.in_entry = n3; settle();
    check_eq("deep_a1", bus.out_base_addr, 64'h1010);
    check_eq("deep_l1", 64'(level), 64'd1);
    tick(); bus.in_entry = n4; settle();
    check_eq("deep_a2", bus.out_base_addr, 64'h1030);
    check_eq("deep_l2", 64'(level), 64'd2);
    tick(); bus.in_entry = marker; settle();
    check_eq("deep_a3", bus.out_base_addr, 64'h1060);
    check_eq("deep_l3", 64'(level), 64'd3);
    check_eq("deep_no_ovf_yet", 64'(err_overflow), 64'd0);
    tick(); settle();
    check_eq("ovf_flag", 64'(err_overflow), 64'd1);
    check_eq("ovf_level_hold", 64'(level), 64'd3);
    check_eq("ovf_addr_hold", bus.out_base_addr, 64'h1060);
    tick(); settle();
    check_eq("unwind_l2", 64'(level), 64'd2);
    check_eq("unwind_a2", bus.out_base_addr, 64'h1030);
    tick(); bus.in_valid = 1'b0; settle();
    check_eq("unwind_l1", 64'(level), 64'd1);
    tick(); settle();
    check_eq("unwind_l0", 64'(level), 64'd0);
    check_eq("unwind_idle", 64'(idle), 64'd1);
    check_eq("ovf_sticky", 64'(err_overflow), 64'd1);
    err_clear = 1'b1;
    tick(); err_clear = 1'b0; settle();
    check_eq("ovf_cleared", 64'(err_overflow), 64'd0);

    // Marker at root level
    bus.in_valid = 1'b1; bus.in_entry = marker;
    tick(); bus.in_valid = 1'b0; settle();
    check_eq("root_marker_hidden", 64'(bus.out_valid), 64'd0);
    check_eq("root_marker_cnt", 64'(count), 64'd1);
    tick(); settle();
    check_eq("unf_flag", 64'(err_underflow), 64'd1);
    check_eq("unf_level", 64'(level), 64'd0);
    check_eq("unf_dropped", 64'(count), 64'd0);
    err_clear = 1'b1;
    tick(); err_clear = 1'b0; settle();
    check_eq("unf_cleared", 64'(err_underflow), 64'd0);
    bus.in_valid = 1'b1; bus.in_entry = marker;
    tick(); bus.in_valid = 1'b0; err_clear = 1'b1;
    tick(); err_clear = 1'b0; settle();
    check_eq("clr_priority", 64'(err_underflow), 64'd0);
    check_eq("clr_priority_cnt", 64'(count), 64'd0);

    // Fill to full with the sink stalled
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_entry = data_ent(i + 1);
      tick();
      mq.push_back(data_ent(i + 1));
    end
    next_id = DEPTH + 1;
    bus.in_entry = data_ent(next_id);
    settle();
    check_eq("full_count", 64'(count), 64'd64);
    check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("full_head", 64'(bus.out_entry), 64'(mq[0]));
    tick(); settle();
    check_eq("full_hold_count", 64'(count), 64'd64);

    // Release the sink with the source still offering: steady stream, wrap
    bus.out_ready = 1'b1;
    #1;
    for (int c = 0; c < 80; c++) begin
      exp_rdy = (mq.size() < DEPTH);
      check_eq("stream_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      check_eq("stream_valid", 64'(bus.out_valid), 64'd1);
      check_eq("stream_entry", 64'(bus.out_entry), 64'(mq[0]));
      tick();
      void'(mq.pop_front());
      if (exp_rdy) begin
        mq.push_back(data_ent(next_id));
        next_id++;
      end
      bus.in_entry = data_ent(next_id);
      settle();
    end
    bus.in_valid = 1'b0;
    #1;
    for (int c = 0; c < DEPTH; c++) begin
      if (mq.size() != 0) begin
        check_eq("drain_entry", 64'(bus.out_entry), 64'(mq[0]));
        tick();
        void'(mq.pop_front());
        settle();
      end
    end
    check_eq("drain_idle", 64'(idle), 64'd1);

    // Root load while busy is refused
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_entry = data_ent(200 + i);
      tick();
    end
    bus.in_valid = 1'b0; settle();
    check_eq("busy_count", 64'(count), 64'd5);
    base_addr = 64'h2000; base_addr_valid = 1'b1;
    tick(); base_addr_valid = 1'b0; settle();
    check_eq("load_err", 64'(err_load), 64'd1);
    check_eq("load_ignored", bus.out_base_addr, 64'h1000);

    // Reset mid-stream
    bus.in_valid = 1'b1; bus.in_entry = data_ent(300); bus.out_ready = 1'b1; reset = 1'b1;
    tick(); settle();
    check_eq("midrst_count", 64'(count), 64'd0);
    check_eq("midrst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_idle", 64'(idle), 64'd1);
    check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("midrst_err_load", 64'(err_load), 64'd0);
    check_eq("midrst_base", bus.out_base_addr, 64'd0);
    reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); settle();
    check_eq("postrst_count", 64'(count), 64'd0);
    check_eq("postrst_entry", 64'(bus.out_entry), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
